// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: reader FSM states and the hex segment table.
// The segment table is shared with the hex-to-segment driver, so keep the two in step.
package seven_seg_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} rd_state_t;

  // Active-high {a,b,c,d,e,f,g}, indexed by nibble value
  localparam logic [6:0] SEG_CODE [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seven_seg_decode.sv
// Inverse segment lookup: active-high {a..g} pattern to nibble, hit=0 when no table entry matches.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] pat,
  output logic       hit,
  output logic [3:0] nibble
);

  always_comb begin
    hit    = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pat == SEG_CODE[i]) begin
        hit    = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_seg_reader.sv
// Recovers per-digit hex values from a multiplexed active-low seven-segment bus.
// Optional SEVSEG_BLANK_DETECT_EN: an all-off digit is reported as blank instead of an error.
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [6:0]                    seg_n,
  input  logic [NUM_DIGITS-1:0]         an_n,
  output logic [4*NUM_DIGITS-1:0]       digits,
  output logic [NUM_DIGITS-1:0]         valid,
  output logic [NUM_DIGITS-1:0]         err,
  output logic                          upd,
  output logic [$clog2(NUM_DIGITS)-1:0] upd_idx
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int SMP_W = 7 + NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [6:0]            seg_s1_q, seg_s2_q;
  logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q;
  logic [SMP_W-1:0]      sample, prev_q;
  logic [NUM_DIGITS-1:0] an_act;
  logic                  one_hot, same, capture, blank;
  logic [IDX_W-1:0]      idx;
  logic                  dec_hit;
  logic [3:0]            dec_nib;
  logic [6:0]            pat;

  rd_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_DIGITS-1:0][3:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0]      valid_q, valid_d, err_q, err_d;
  logic                       upd_q, upd_d;
  logic [IDX_W-1:0]           upd_idx_q, upd_idx_d;

  assign sample  = {seg_s2_q, an_s2_q};
  assign an_act  = ~an_s2_q;
  assign one_hot = $onehot(an_act);
  assign same    = (sample == prev_q);
  assign pat     = ~seg_s2_q;

`ifdef SEVSEG_BLANK_DETECT_EN
  assign blank = (pat == SEG_BLANK);
`else
  assign blank = 1'b0;
`endif

  seven_seg_decode u_dec (
    .pat    (pat),
    .hit    (dec_hit),
    .nibble (dec_nib)
  );

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_act[i]) idx = IDX_W'(i);
    end
  end

  // State register, stability counter and previous-sample register
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      an_s1_q  <= '0;
      an_s2_q  <= '0;
      prev_q   <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
    end else begin
      seg_s1_q <= seg_n;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= an_n;
      an_s2_q  <= an_s1_q;
      prev_q   <= sample;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  // A fresh one-hot sample starts a run of length 1, which already completes when STABLE_CYCLES=1
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (one_hot) begin
          state_d = (CNT_ONE == CNT_MAX) ? HELD : SETTLE;
          cnt_d   = (CNT_ONE == CNT_MAX) ? '0 : CNT_ONE;
        end
      end
      SETTLE: begin
        if (!one_hot) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!same) begin
          state_d = (CNT_ONE == CNT_MAX) ? HELD : SETTLE;
          cnt_d   = (CNT_ONE == CNT_MAX) ? '0 : CNT_ONE;
        end else if (cnt_q + CNT_ONE == CNT_MAX) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        cnt_d = '0;
        if (!one_hot) begin
          state_d = IDLE;
        end else if (!same) begin
          state_d = (CNT_ONE == CNT_MAX) ? HELD : SETTLE;
          cnt_d   = (CNT_ONE == CNT_MAX) ? '0 : CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Capture on every transition into HELD; a HELD sample that stays unchanged never re-captures
  always_comb begin
    capture = (state_d == HELD) && !((state_q == HELD) && same);
  end

  always_comb begin
    dig_d     = dig_q;
    valid_d   = valid_q;
    err_d     = err_q;
    upd_d     = capture;
    upd_idx_d = upd_idx_q;
    if (capture) begin
      upd_idx_d      = idx;
      valid_d[idx]   = dec_hit;
      err_d[idx]     = !dec_hit && !blank;
      if (dec_hit) dig_d[idx] = dec_nib;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dig_q     <= '0;
      valid_q   <= '0;
      err_q     <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
    end else begin
      dig_q     <= dig_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
    end
  end

  assign digits  = dig_q;
  assign valid   = valid_q;
  assign err     = err_q;
  assign upd     = upd_q;
  assign upd_idx = upd_idx_q;

endmodule
